// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines x 4 words, 128-bit memory blocks.
// Optional DCACHE_STATS_EN macro adds HIT_COUNT / MISS_COUNT access counters.
module dcache (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          READ,
   input  logic          WRITE,
   input  logic [2:0]    FUNCT3,
   input  logic [31:0]   ADDRESS,
   input  logic [31:0]   WRITEDATA,
   output logic [31:0]   READDATA,
   output logic          BUSYWAIT,
   output logic          MEM_READ,
   output logic          MEM_WRITE,
   output logic [27:0]   MEM_ADDRESS,
   output logic [127:0]  MEM_WRITEDATA,
   input  logic [127:0]  MEM_READDATA,
   input  logic          MEM_BUSYWAIT,
   output logic [1:0]    FSM_STATE
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]   HIT_COUNT,
   output logic [31:0]   MISS_COUNT
`endif
);

   // Handshake: READ/WRITE is a request held stable by the CPU; it completes at the
   // posedge where BUSYWAIT is low. Memory side: MEM_READ/MEM_WRITE held until a posedge with MEM_BUSYWAIT low.
   typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FETCH = 2'd2, UPDATE = 2'd3} state_t;

   state_t        state, state_next;
   logic [31:0]   data_mem [8][4];
   logic [24:0]   tag_mem [8];
   logic [7:0]    valid, dirty;
   logic [127:0]  fill_buf;

   logic [2:0]    idx;
   logic [1:0]    word_sel;
   logic          req, hit, access_done;
   logic [31:0]   cur_word, load_val, wdata;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [3:0]    be;

   assign idx         = ADDRESS[6:4];
   assign word_sel    = ADDRESS[3:2];
   assign req         = READ | WRITE;
   assign hit         = valid[idx] && (tag_mem[idx] == ADDRESS[31:7]);
   assign access_done = !RESET && (state == IDLE) && req && hit;
   assign BUSYWAIT    = !RESET && req && !((state == IDLE) && hit);
   assign FSM_STATE   = state;

   assign cur_word = data_mem[idx][word_sel];
   assign rd_byte  = cur_word[{ADDRESS[1:0], 3'b000} +: 8];
   assign rd_half  = ADDRESS[1] ? cur_word[31:16] : cur_word[15:0];

   always_comb begin
      load_val = cur_word;
      case (FUNCT3)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_val = {24'h0, rd_byte};
         3'b101:  load_val = {16'h0, rd_half};
         default: load_val = cur_word;
      endcase
      READDATA = RESET ? 32'h0 : load_val;
   end

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      be    = 4'b1111;
      wdata = WRITEDATA;
      case (FUNCT3[1:0])
         2'b00: begin
            be    = 4'b0001 << ADDRESS[1:0];
            wdata = {4{WRITEDATA[7:0]}};
         end
         2'b01: begin
            be    = ADDRESS[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WRITEDATA[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = WRITEDATA;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = state;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = 28'h0;
      MEM_WRITEDATA = 128'h0;
      case (state)
         IDLE: begin
            if (req && !hit) state_next = dirty[idx] ? WRITEBACK : FETCH;
         end
         WRITEBACK: begin
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {tag_mem[idx], idx};
            MEM_WRITEDATA = {data_mem[idx][3], data_mem[idx][2], data_mem[idx][1], data_mem[idx][0]};
            if (!MEM_BUSYWAIT) state_next = FETCH;
         end
         FETCH: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = ADDRESS[31:4];
            if (!MEM_BUSYWAIT) state_next = UPDATE;
         end
         UPDATE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (RESET) begin
         MEM_READ      = 1'b0;
         MEM_WRITE     = 1'b0;
         MEM_ADDRESS   = 28'h0;
         MEM_WRITEDATA = 128'h0;
      end
   end

   // Line storage carries no reset; valid bits gate every use of it.
   always_ff @(posedge CLK) begin
      if (state == FETCH && !MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
      if (!RESET) begin
         if (state == UPDATE) begin
            for (int w = 0; w < 4; w++) data_mem[idx][w] <= fill_buf[32*w +: 32];
            tag_mem[idx] <= ADDRESS[31:7];
         end else if (access_done && WRITE) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) data_mem[idx][word_sel][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid <= 8'h0;
         dirty <= 8'h0;
      end else if (state == UPDATE) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (access_done && WRITE) begin
         dirty[idx] <= 1'b1;
      end
   end

`ifdef DCACHE_STATS_EN
   // missed remembers that the pending access already counted as a miss.
   logic missed;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         HIT_COUNT  <= 32'h0;
         MISS_COUNT <= 32'h0;
         missed     <= 1'b0;
      end else begin
         if (state == IDLE && req && !hit) begin
            MISS_COUNT <= MISS_COUNT + 32'd1;
            missed     <= 1'b1;
         end
         if (access_done) begin
            if (!missed) HIT_COUNT <= HIT_COUNT + 32'd1;
            missed <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: random loads/stores against a flat byte-array memory image, plus
// directed miss, writeback, reset-abort and counter scenarios.
`timescale 1ns/1ps
module tb_dcache;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          READ, WRITE;
   logic [2:0]    FUNCT3;
   logic [31:0]   ADDRESS, WRITEDATA;
   logic [31:0]   READDATA;
   logic          BUSYWAIT;
   logic          MEM_READ, MEM_WRITE;
   logic [27:0]   MEM_ADDRESS;
   logic [127:0]  MEM_WRITEDATA, MEM_READDATA;
   logic          MEM_BUSYWAIT;
   logic [1:0]    FSM_STATE;
`ifdef DCACHE_STATS_EN
   logic [31:0]   HIT_COUNT, MISS_COUNT;
`endif

   dcache dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNCT3(FUNCT3),
      .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
      .FSM_STATE(FSM_STATE)
`ifdef DCACHE_STATS_EN
      , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- counters / scoreboard ----------------
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [31:0]   exp_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Coherent memory view: what any load must observe, independent of where the byte lives.
   logic [7:0]    ref_mem [1024];
   logic          res_valid [8];
   logic [24:0]   res_tag [8];
   int            exp_hits = 0;
   int            exp_misses = 0;

   function automatic logic [31:0] load_exp(input logic [2:0] f3, input logic [31:0] a);
      logic [9:0]  b;
      logic [7:0]  by;
      logic [15:0] hw;
      logic [31:0] w;
      b  = a[9:0];
      by = ref_mem[b];
      hw = {ref_mem[{b[9:1], 1'b1}], ref_mem[{b[9:1], 1'b0}]};
      w  = {ref_mem[{b[9:2], 2'd3}], ref_mem[{b[9:2], 2'd2}], ref_mem[{b[9:2], 2'd1}], ref_mem[{b[9:2], 2'd0}]};
      case (f3)
         3'b000:  return {{24{by[7]}}, by};
         3'b001:  return {{16{hw[15]}}, hw};
         3'b100:  return {24'h0, by};
         3'b101:  return {16'h0, hw};
         default: return w;
      endcase
   endfunction

   function automatic void store_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic [9:0] b;
      b = a[9:0];
      case (f3[1:0])
         2'b00: ref_mem[b] = d[7:0];
         2'b01: begin
            ref_mem[{b[9:1], 1'b0}] = d[7:0];
            ref_mem[{b[9:1], 1'b1}] = d[15:8];
         end
         default: for (int k = 0; k < 4; k++) ref_mem[{b[9:2], 2'(k)}] = d[8*k +: 8];
      endcase
   endfunction

   function automatic logic [127:0] block_of(input int blk);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_mem[10'(blk*16 + k)];
      return r;
   endfunction

   // ---------------- main memory harness ----------------
   logic [127:0]  mem_blk [64];
   int            mem_cnt, mem_lat;
   bit            lat_hold = 1'b0;
   logic [27:0]   wb_addr_q[$];
   logic [127:0]  wb_data_q[$];
   logic [27:0]   fetch_addr_q[$];

   assign MEM_READDATA = mem_blk[MEM_ADDRESS[5:0]];
   assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (lat_hold || (mem_cnt < mem_lat));

   always @(posedge CLK) begin
      if (RESET) begin
         mem_cnt <= 0;
         mem_lat <= 1;
      end else if (MEM_READ || MEM_WRITE) begin
         if (MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
         else begin
            mem_cnt <= 0;
            mem_lat <= $urandom_range(0, 3);
            if (MEM_WRITE) begin
               mem_blk[MEM_ADDRESS[5:0]] = MEM_WRITEDATA;
               wb_addr_q.push_back(MEM_ADDRESS);
               wb_data_q.push_back(MEM_WRITEDATA);
            end else begin
               fetch_addr_q.push_back(MEM_ADDRESS);
            end
         end
      end else begin
         mem_cnt <= 0;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      if (RESET === 1'b0) begin
         check("mem_rd_wr_exclusive", MEM_READ && MEM_WRITE, 1'b0);
         if (READ && !WRITE && !BUSYWAIT) begin
            if (exp_q.size() == 0) check("load_unexpected", 1'b1, 1'b0);
            else check("load_data", READDATA, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      bit miss;
      int n;
      miss = !(res_valid[addr[6:4]] && res_tag[addr[6:4]] == addr[31:7]);
      READ      = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      WRITE     = wr;
      FUNCT3    = f3;
      ADDRESS   = addr;
      WRITEDATA = wd;
      if (!wr) exp_q.push_back(load_exp(f3, addr));
      @(negedge CLK);
      check("busy_first_cycle", BUSYWAIT, miss);
      n = 0;
      while (BUSYWAIT && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (BUSYWAIT) check("busy_timeout", BUSYWAIT, 1'b0);
      @(posedge CLK);
      #1;
      READ  = 1'b0;
      WRITE = 1'b0;
      if (wr) store_ref(f3, addr, wd);
      res_valid[addr[6:4]] = 1'b1;
      res_tag[addr[6:4]]   = addr[31:7];
      if (miss) exp_misses++;
      else      exp_hits++;
   endtask

   task automatic idle_cycle();
      @(negedge CLK);
      check("idle_busy", BUSYWAIT, 1'b0);
      @(posedge CLK);
      #1;
   endtask

   task automatic resync_after_reset();
      for (int b = 0; b < 64; b++)
         for (int k = 0; k < 16; k++) ref_mem[10'(b*16 + k)] = mem_blk[b][8*k +: 8];
      for (int i = 0; i < 8; i++) res_valid[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   // ---------------- stimulus ----------------
   logic [127:0]  blk_exp;
   logic [2:0]    f3;
   logic [31:0]   a;
   bit            wr;
   int            n;

   initial begin
      RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; FUNCT3 = 3'b010;
      ADDRESS = 32'h0; WRITEDATA = 32'h0;
      for (int b = 0; b < 64; b++) mem_blk[b] = {$urandom, $urandom, $urandom, $urandom};
      resync_after_reset();

      repeat (3) @(posedge CLK);
      #1;
      READ = 1'b1; ADDRESS = 32'h40;
      @(negedge CLK);
      check("reset_readdata", READDATA, 32'h0);
      check("reset_mem_read", MEM_READ, 1'b0);
      check("reset_mem_write", MEM_WRITE, 1'b0);
      check("reset_mem_address", MEM_ADDRESS, 28'h0);
      @(posedge CLK);
      #1;
      RESET = 1'b0; READ = 1'b0;

      // cold miss on 0x40
      fetch_addr_q.delete(); wb_addr_q.delete(); wb_data_q.delete();
      access(1'b0, 3'b010, 32'h40, 32'h0);
      check("cold_fetch_count", fetch_addr_q.size(), 1);
      if (fetch_addr_q.size() > 0) check("cold_fetch_addr", fetch_addr_q[0], 28'h4);
      check("cold_wb_count", wb_addr_q.size(), 0);

      // store/load hits, byte sign handling
      access(1'b1, 3'b010, 32'h40, 32'h1234_5678);
      access(1'b0, 3'b010, 32'h40, 32'h0);
      access(1'b1, 3'b000, 32'h41, 32'h0000_0080);
      access(1'b0, 3'b000, 32'h41, 32'h0);
      access(1'b0, 3'b100, 32'h41, 32'h0);
      access(1'b0, 3'b001, 32'h43, 32'h0);
      access(1'b0, 3'b101, 32'h42, 32'h0);
      idle_cycle();

      // dirty victim writeback before refill
      blk_exp = block_of(4);
      fetch_addr_q.delete(); wb_addr_q.delete(); wb_data_q.delete();
      access(1'b0, 3'b010, 32'hC0, 32'h0);
      check("wb_count", wb_addr_q.size(), 1);
      if (wb_addr_q.size() > 0) begin
         check("wb_addr", wb_addr_q[0], 28'h4);
         check("wb_data", wb_data_q[0], blk_exp);
      end
      check("refill_fetch_count", fetch_addr_q.size(), 1);
      if (fetch_addr_q.size() > 0) check("refill_fetch_addr", fetch_addr_q[0], 28'hC);

      // reset while a fetch is stalled in memory
      lat_hold = 1'b1;
      READ = 1'b1; WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = 32'h40;
      @(negedge CLK);
      n = 0;
      while (!MEM_READ && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("fetch_started", MEM_READ, 1'b1);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0; READ = 1'b0; lat_hold = 1'b0;
      @(negedge CLK);
      check("mem_read_dropped", MEM_READ, 1'b0);
      check("busy_after_reset", BUSYWAIT, 1'b0);
      @(posedge CLK);
      #1;
      resync_after_reset();

      // one miss then three hits
      access(1'b0, 3'b010, 32'h40, 32'h0);
      access(1'b0, 3'b010, 32'h40, 32'h0);
      access(1'b0, 3'b010, 32'h44, 32'h0);
      access(1'b0, 3'b010, 32'h48, 32'h0);
`ifdef DCACHE_STATS_EN
      @(negedge CLK);
      check("stats_miss_count", MISS_COUNT, 32'd1);
      check("stats_hit_count", HIT_COUNT, 32'd3);
      @(posedge CLK);
      #1;
`endif

      // random traffic
      for (int i = 0; i < 300; i++) begin
         wr = ($urandom_range(0, 2) == 0);
         a  = {22'h0, 10'($urandom_range(0, 1023))};
         if (wr) f3 = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 4))
               0:       f3 = 3'b000;
               1:       f3 = 3'b001;
               2:       f3 = 3'b010;
               3:       f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end
         access(wr, f3, a, $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      // read back every word through the cache to flush out lost writebacks
      for (int w = 0; w < 256; w++) access(1'b0, 3'b010, 32'(w*4), 32'h0);

      check("scoreboard_drained", exp_q.size(), 0);
`ifdef DCACHE_STATS_EN
      @(negedge CLK);
      check("final_hit_count", HIT_COUNT, 32'(exp_hits));
      check("final_miss_count", MISS_COUNT, 32'(exp_misses));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500_000;
      n_bad++;
      $display("FAIL watchdog: got timeout, want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 No parameters; geometry fixed: 8 lines x 4 words (16 B/line), direct-mapped, write-back, write-allocate.
REQ-002 CLK  input  1  clock; all state updates on posedge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-004 READ  input  1  CPU load request from MEM stage.
REQ-005 WRITE  input  1  CPU store request from MEM stage.
REQ-006 FUNCT3  input  3  access width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ADDRESS  input  32  byte address: tag [31:7], index [6:4], word [3:2], byte [1:0].
REQ-008 WRITEDATA  input  32  store data; low byte/half used for SB/SH.
REQ-009 READDATA  output  32  load result, extended per FUNCT3; feeds MEM_IN of MEM/WB register.
REQ-010 BUSYWAIT  output  1  stall to CPU and all pipeline registers.
REQ-011 MEM_READ  output  1  block fetch request to main memory.
REQ-012 MEM_WRITE  output  1  block writeback request to main memory.
REQ-013 MEM_ADDRESS  output  28  block address {tag,index}.
REQ-014 MEM_WRITEDATA  output  128  victim block, word 0 in [31:0].
REQ-015 MEM_READDATA  input  128  fetched block, word 0 in [31:0].
REQ-016 MEM_BUSYWAIT  input  1  high while main memory is servicing a request.

Function
REQ-017 Hit = valid[index] && tag[index]==ADDRESS[31:7], evaluated combinationally.
REQ-018 No request (READ=WRITE=0): BUSYWAIT=0, no state change.
REQ-019 Read hit: READDATA valid same cycle, BUSYWAIT=0, zero-stall.
REQ-020 Loads: B/H sign-extend, BU/HU zero-extend, byte lane selected by ADDRESS[1:0]; H uses ADDRESS[1], ignores ADDRESS[0]; W ignores ADDRESS[1:0].
REQ-021 Write hit: selected bytes updated at next posedge, dirty set, BUSYWAIT=0.
REQ-022 READ and WRITE both high: treated as write.
REQ-023 Miss: BUSYWAIT asserted combinationally in the request cycle and held until the cycle the access hits.
REQ-024 FSM IDLE: on miss -> WRITEBACK if dirty[index], else FETCH.
REQ-025 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=victim; -> FETCH on posedge with MEM_BUSYWAIT=0.
REQ-026 FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4]; -> UPDATE on posedge with MEM_BUSYWAIT=0, capturing MEM_READDATA.
REQ-027 UPDATE: line written, tag loaded, valid=1, dirty=0; -> IDLE; request then hits and completes as REQ-019/021.
REQ-028 MEM_READ and MEM_WRITE never both high; both low in IDLE and UPDATE.
REQ-029 CPU inputs held stable by stalled pipeline while BUSYWAIT=1; changes mid-miss are not supported.

Reset
REQ-030 RESET clears all valid and dirty bits, FSM -> IDLE, MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, READDATA=0 while reset asserted.
REQ-031 Reset mid-miss abandons the transaction; memory request drops the following cycle; dirty victim data is lost.

Configuration
REQ-032 Macro DCACHE_STATS_EN defined: outputs HIT_COUNT[31:0], MISS_COUNT[31:0] added; hit increments once per completed access not preceded by a miss, miss once per IDLE->WRITEBACK/FETCH transition; reset to 0, wrap at 2^32-1.
REQ-033 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-034 After reset, LW 0x0000_0040 -> BUSYWAIT=1, FETCH MEM_ADDRESS=0x0000004, then hit; READDATA = word 0 of MEM_READDATA.
REQ-035 SW 0x1234_5678 @0x40 then LW @0x40 -> READDATA=0x1234_5678, BUSYWAIT=0 both cycles.
REQ-036 SB 0x80 @0x41, LB @0x41 -> 0xFFFF_FF80; LBU @0x41 -> 0x0000_0080.
REQ-037 Dirty line @0x40, LW 0x0000_00C0 -> WRITEBACK MEM_ADDRESS=0x0000004 with stored data, then FETCH 0x000000C.
REQ-038 RESET during FETCH with MEM_BUSYWAIT=1 -> MEM_READ=0 next cycle; subsequent LW @0x40 misses.
REQ-039 DCACHE_STATS_EN: miss then 3 hits -> MISS_COUNT=1, HIT_COUNT=3.
